// File: rtl/reorder_queue_output.sv
// rtl/reorder_queue_output.sv - drains finished reorder tags in tag order as engine beats
// Tracks finished tags, reads each head tag's payload from the per-DW banks, then releases the tag.
module reorder_queue_output #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_TAG_WIDTH = 5,
  parameter int C_TAG_DW_COUNT_WIDTH = 8,
  parameter int C_DATA_ADDR_STRIDE_WIDTH = 5,
  parameter int C_DATA_ADDR_WIDTH = 10,
  localparam int C_PCI_DATA_WORD = C_PCI_DATA_WIDTH / 32,
  localparam int C_NUM_TAGS = 2 ** C_TAG_WIDTH,
  localparam int C_PCI_DATA_COUNT_WIDTH = $clog2(C_PCI_DATA_WORD + 1)
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic [C_NUM_TAGS-1:0]                        TAG_FINISH,
  output logic [C_NUM_TAGS-1:0]                        TAG_CLEAR,
  input  logic                                         PKT_VALID,
  input  logic [C_TAG_WIDTH-1:0]                       PKT_TAG,
  input  logic [C_TAG_DW_COUNT_WIDTH-1:0]              PKT_WORDS,
  input  logic                                         PKT_ERR,
  output logic [C_DATA_ADDR_WIDTH*C_PCI_DATA_WORD-1:0] RAM_ADDR,
  input  logic [C_PCI_DATA_WIDTH-1:0]                  RAM_DATA,
  output logic                                         ENG_VALID,
  output logic [C_PCI_DATA_WIDTH-1:0]                  ENG_DATA,
  output logic [C_PCI_DATA_COUNT_WIDTH-1:0]            ENG_DATA_EN,
  output logic                                         ENG_DONE,
  output logic                                         ENG_ERR,
  output logic [C_TAG_WIDTH-1:0]                       ENG_TAG
);

  localparam logic [C_TAG_DW_COUNT_WIDTH-1:0] WORDS_PER_BEAT = C_TAG_DW_COUNT_WIDTH'(C_PCI_DATA_WORD);

  typedef enum logic {IDLE, READ} state_t;

  state_t                            state;
  logic [C_TAG_WIDTH-1:0]            head;
  logic [C_NUM_TAGS-1:0]             finished;
  logic [C_NUM_TAGS-1:0]             err;
  logic [C_TAG_DW_COUNT_WIDTH-1:0]   words [C_NUM_TAGS];
  logic [C_TAG_DW_COUNT_WIDTH-1:0]   remain;
  logic                              last_err;
  logic [C_DATA_ADDR_WIDTH-1:0]      rd_addr;
  logic                              rd_valid;
  logic                              rd_last;
  logic                              rd_err;
  logic [C_PCI_DATA_COUNT_WIDTH-1:0] rd_cnt;
  logic [C_TAG_WIDTH-1:0]            rd_tag;

  logic                              cur_last;
  logic                              drain;
  logic [C_PCI_DATA_COUNT_WIDTH-1:0] cur_cnt;
  logic [C_NUM_TAGS-1:0]             head_onehot;
  logic [C_DATA_ADDR_WIDTH-1:0]      head_base;

  always_comb begin
    cur_last    = remain <= WORDS_PER_BEAT;
    cur_cnt     = cur_last ? C_PCI_DATA_COUNT_WIDTH'(remain) : C_PCI_DATA_COUNT_WIDTH'(C_PCI_DATA_WORD);
    drain       = (state == READ) && cur_last;
    head_onehot = {{(C_NUM_TAGS-1){1'b0}}, 1'b1} << head;
    head_base   = C_DATA_ADDR_WIDTH'({head, {C_DATA_ADDR_STRIDE_WIDTH{1'b0}}});
  end

  // Every bank reads the same row: DW n of a tag sits in bank n mod W, so no rotation is needed.
  assign RAM_ADDR = {C_PCI_DATA_WORD{rd_addr}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      head        <= '0;
      finished    <= '0;
      err         <= '0;
      for (int i = 0; i < C_NUM_TAGS; i++) words[i] <= '0;
      remain      <= '0;
      last_err    <= 1'b0;
      rd_addr     <= '0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_err      <= 1'b0;
      rd_cnt      <= '0;
      rd_tag      <= '0;
      TAG_CLEAR   <= '0;
      ENG_VALID   <= 1'b0;
      ENG_DATA    <= '0;
      ENG_DATA_EN <= '0;
      ENG_DONE    <= 1'b0;
      ENG_ERR     <= 1'b0;
      ENG_TAG     <= '0;
    end else begin
      TAG_CLEAR <= '0;
      rd_valid  <= 1'b0;

      case (state)
        IDLE: begin
          if (finished[head]) begin
            remain   <= words[head];
            last_err <= err[head];
            rd_addr  <= head_base;
            state    <= READ;
          end
        end
        READ: begin
          rd_valid <= 1'b1;
          rd_cnt   <= cur_cnt;
          rd_last  <= cur_last;
          rd_err   <= last_err;
          rd_tag   <= head;
          if (cur_last) begin
            remain    <= '0;
            rd_addr   <= '0;
            head      <= head + C_TAG_WIDTH'(1);
            TAG_CLEAR <= head_onehot;
            state     <= IDLE;
          end else begin
            remain  <= remain - WORDS_PER_BEAT;
            rd_addr <= rd_addr + C_DATA_ADDR_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // A new finish or packet for the tag being released takes priority over the release.
      if (drain) begin
        words[head] <= '0;
        err[head]   <= 1'b0;
      end
      if (PKT_VALID) begin
        words[PKT_TAG] <= PKT_WORDS;
        err[PKT_TAG]   <= PKT_ERR | (err[PKT_TAG] & ~(drain && (PKT_TAG == head)));
      end
      finished <= (finished & ~(drain ? head_onehot : '0)) | TAG_FINISH;

      ENG_VALID   <= rd_valid;
      ENG_DATA    <= rd_valid ? RAM_DATA : '0;
      ENG_DATA_EN <= rd_valid ? rd_cnt : '0;
      ENG_DONE    <= rd_valid && rd_last;
      ENG_ERR     <= rd_valid && rd_last && rd_err;
      ENG_TAG     <= rd_valid ? rd_tag : '0;
    end
  end

endmodule

// File: tb/tb_reorder_queue_output.sv
// tb/tb_reorder_queue_output.sv - scoreboard bench for reorder_queue_output
// Expected beats and tag releases are queued at stimulus time; a negedge monitor pops and compares.
module tb_reorder_queue_output;

  localparam int W  = 4;
  localparam int NT = 32;

  logic           CLK;
  logic           RST;
  logic [NT-1:0]  TAG_FINISH;
  logic [NT-1:0]  TAG_CLEAR;
  logic           PKT_VALID;
  logic [4:0]     PKT_TAG;
  logic [7:0]     PKT_WORDS;
  logic           PKT_ERR;
  logic [39:0]    RAM_ADDR;
  logic [127:0]   RAM_DATA;
  logic           ENG_VALID;
  logic [127:0]   ENG_DATA;
  logic [2:0]     ENG_DATA_EN;
  logic           ENG_DONE;
  logic           ENG_ERR;
  logic [4:0]     ENG_TAG;

  reorder_queue_output dut (
    .CLK(CLK), .RST(RST),
    .TAG_FINISH(TAG_FINISH), .TAG_CLEAR(TAG_CLEAR),
    .PKT_VALID(PKT_VALID), .PKT_TAG(PKT_TAG), .PKT_WORDS(PKT_WORDS), .PKT_ERR(PKT_ERR),
    .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA),
    .ENG_VALID(ENG_VALID), .ENG_DATA(ENG_DATA), .ENG_DATA_EN(ENG_DATA_EN),
    .ENG_DONE(ENG_DONE), .ENG_ERR(ENG_ERR), .ENG_TAG(ENG_TAG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bank contents identify bank and address, so a wrong read address shows up as wrong data.
  function automatic logic [31:0] ram_word(int bank, logic [9:0] addr);
    return {16'hA500 | 16'(bank), 6'b0, addr};
  endfunction

  always @(posedge CLK)
    for (int i = 0; i < W; i++) RAM_DATA[32*i +: 32] <= ram_word(i, RAM_ADDR[10*i +: 10]);

  typedef struct packed {
    logic [127:0] data;
    logic [2:0]   en;
    logic         done;
    logic         err;
    logic [4:0]   tag;
  } beat_t;

  beat_t      exp_q[$];
  logic [4:0] clr_q[$];
  int         n_total;
  int         n_pass;
  int         beats_seen;
  logic [NT-1:0] prev_clear;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_beat(int tag, int k, int en, bit done, bit err);
    beat_t b;
    b.data = '0;
    for (int i = 0; i < en; i++) b.data[32*i +: 32] = ram_word(i, {5'(tag), 5'(k)});
    b.en   = 3'(en);
    b.done = done;
    b.err  = err;
    b.tag  = 5'(tag);
    exp_q.push_back(b);
  endtask

  task automatic expect_tag(int tag, int words, bit err);
    int beats;
    int rem;
    beats = (words == 0) ? 1 : (words + W - 1) / W;
    for (int k = 0; k < beats; k++) begin
      rem = words - W * k;
      push_beat(tag, k, (rem > W) ? W : rem, k == beats - 1, err);
    end
    clr_q.push_back(5'(tag));
  endtask

  beat_t         mon_e;
  logic [127:0]  mon_m;
  logic [NT-1:0] mon_oh;
  logic [4:0]    mon_ct;

  always @(negedge CLK) begin
    if (!RST) begin
      if (ENG_VALID) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got tag %0d en %0d, expected no beat", ENG_TAG, ENG_DATA_EN);
        end else begin
          mon_e = exp_q.pop_front();
          mon_m = '0;
          for (int i = 0; i < W; i++)
            if (i < int'(mon_e.en)) mon_m[32*i +: 32] = ENG_DATA[32*i +: 32];
          check("beat_tag", 128'(ENG_TAG), 128'(mon_e.tag));
          check("beat_en", 128'(ENG_DATA_EN), 128'(mon_e.en));
          check("beat_done", 128'(ENG_DONE), 128'(mon_e.done));
          check("beat_data", mon_m, mon_e.data);
          if (mon_e.done) begin
            mon_oh = {{(NT-1){1'b0}}, 1'b1} << mon_e.tag;
            check("beat_err", 128'(ENG_ERR), 128'(mon_e.err));
            check("clear_before_done", 128'(prev_clear), 128'(mon_oh));
          end
        end
      end
      if (TAG_CLEAR != '0) begin
        if (clr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_clear: got %0h expected none", TAG_CLEAR);
        end else begin
          mon_ct = clr_q.pop_front();
          mon_oh = {{(NT-1){1'b0}}, 1'b1} << mon_ct;
          check("tag_clear", 128'(TAG_CLEAR), 128'(mon_oh));
        end
      end
    end
    prev_clear = TAG_CLEAR;
  end

  task automatic write_pkt(int tag, int words, bit err);
    @(negedge CLK);
    PKT_VALID = 1'b1; PKT_TAG = 5'(tag); PKT_WORDS = 8'(words); PKT_ERR = err;
    @(negedge CLK);
    PKT_VALID = 1'b0; PKT_ERR = 1'b0;
  endtask

  task automatic pulse_finish(logic [NT-1:0] mask);
    @(negedge CLK);
    TAG_FINISH = mask;
    @(negedge CLK);
    TAG_FINISH = '0;
  endtask

  task automatic wait_drain(int budget, string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || clr_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, 128'(exp_q.size() + clr_q.size()), 128'(0));
    repeat (3) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; TAG_FINISH = '0; PKT_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete(); clr_q.delete();
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic check_outputs_zero(string tag_name);
    check({tag_name, "_eng_ctrl"}, 128'({ENG_VALID, ENG_DATA_EN, ENG_DONE, ENG_ERR, ENG_TAG}), 128'(0));
    check({tag_name, "_eng_data"}, ENG_DATA, 128'(0));
    check({tag_name, "_tag_clear"}, 128'(TAG_CLEAR), 128'(0));
    check({tag_name, "_ram_addr"}, 128'(RAM_ADDR), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  seen0;
    int  n;
    int  cnt;
    bit  done0;
    bit  done5;
    n_total = 0; n_pass = 0; beats_seen = 0;
    RST = 1'b1; TAG_FINISH = '0; PKT_VALID = 1'b0; PKT_TAG = '0; PKT_WORDS = '0; PKT_ERR = 1'b0;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RST = 1'b0;
    @(negedge CLK);

    // Tag 0, 10 DW: beats of 4,4,2 from rows 0,1,2; first beat four cycles after the finish.
    write_pkt(0, 10, 0);
    push_beat(0, 0, 4, 0, 0);
    push_beat(0, 1, 4, 0, 0);
    push_beat(0, 2, 2, 1, 0);
    clr_q.push_back(5'd0);
    pulse_finish(32'h1);
    repeat (2) @(negedge CLK);
    check("t1_valid_f3", 128'(ENG_VALID), 128'(0));
    @(negedge CLK);
    check("t1_valid_f4", 128'(ENG_VALID), 128'(1));
    wait_drain(20, "t1_drain");

    // Tag 1 finishes first but must wait for tag 0.
    do_reset();
    write_pkt(1, 4, 0);
    pulse_finish(32'h2);
    seen0 = beats_seen;
    repeat (10) @(negedge CLK);
    check("t2_hold", 128'(beats_seen - seen0), 128'(0));
    write_pkt(0, 8, 0);
    expect_tag(0, 8, 0);
    expect_tag(1, 4, 0);
    pulse_finish(32'h1);
    wait_drain(30, "t2_drain");

    // Tag 2 with 3 DW, then the error-only zero-word tag 3.
    write_pkt(2, 3, 0);
    write_pkt(3, 0, 1);
    expect_tag(2, 3, 0);
    push_beat(3, 0, 0, 1, 1);
    clr_q.push_back(5'd3);
    pulse_finish(32'hC);
    wait_drain(30, "t3_drain");

    // Wrap through all 32 tags; tags 0 and 5 are re-finished in their own TAG_CLEAR cycle.
    do_reset();
    for (int t = 0; t < NT; t++) write_pkt(t, 1, 0);
    for (int t = 0; t < NT; t++) expect_tag(t, 1, 0);
    expect_tag(0, 2, 0);
    pulse_finish('1);
    done0 = 0; done5 = 0; n = 0;
    while (!(done0 && done5) && n < 200) begin
      @(negedge CLK);
      n++;
      TAG_FINISH = '0; PKT_VALID = 1'b0;
      if (!done0 && TAG_CLEAR == 32'h1) begin
        PKT_VALID = 1'b1; PKT_TAG = 5'd0; PKT_WORDS = 8'd2; TAG_FINISH = 32'h1; done0 = 1;
      end else if (!done5 && TAG_CLEAR == 32'h20) begin
        PKT_VALID = 1'b1; PKT_TAG = 5'd5; PKT_WORDS = 8'd3; TAG_FINISH = 32'h20; done5 = 1;
      end
    end
    @(negedge CLK);
    TAG_FINISH = '0; PKT_VALID = 1'b0;
    check("t4_refinish_seen", 128'({done0, done5}), 128'(2'b11));
    wait_drain(200, "t4_pass1");
    for (int t = 1; t <= 4; t++) write_pkt(t, 1, 0);
    for (int t = 1; t <= 4; t++) expect_tag(t, 1, 0);
    expect_tag(5, 3, 0);
    pulse_finish(32'h1E);
    wait_drain(60, "t4_pass2");

    // Reset while beat 2 of a 5-beat tag is on the output, then replay tag 0 from row 0.
    do_reset();
    write_pkt(0, 20, 0);
    expect_tag(0, 20, 0);
    pulse_finish(32'h1);
    n = 0; cnt = 0;
    while (cnt < 2 && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
      if (ENG_VALID) cnt++;
    end
    check("t5_beat2_reached", 128'(cnt), 128'(2));
    #1 RST = 1'b1;
    #1;
    check_outputs_zero("t5_midreset");
    exp_q.delete(); clr_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    write_pkt(0, 6, 0);
    expect_tag(0, 6, 0);
    pulse_finish(32'h1);
    wait_drain(30, "t5_replay");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reorder_queue_output.md
# reorder_queue_output

Drains the reorder queue in tag order. It tracks which tags the input stage has finished and reads each finished tag's payload back from the per-DW data RAM banks, starting at the oldest outstanding tag. It emits the payload as in-order beats to the engine side, then releases the tag with a one-cycle TAG_CLEAR pulse. It sits directly downstream of reorder_queue_input: it consumes that block's TAG_FINISH and PKT_* outputs and drives its TAG_CLEAR input.

## Interface
- C_PCI_DATA_WIDTH, 128, payload width; C_PCI_DATA_WORD = C_PCI_DATA_WIDTH/32 (W)
- C_TAG_WIDTH, 5, tag width; C_NUM_TAGS = 2**C_TAG_WIDTH
- C_TAG_DW_COUNT_WIDTH, 8, width of per-tag DW count
- C_DATA_ADDR_STRIDE_WIDTH, 5, log2 of RAM addresses per tag
- C_DATA_ADDR_WIDTH, 10, RAM address width
- C_PCI_DATA_COUNT_WIDTH, clog2s(W+1), width of a per-beat DW count
- CLK  in  1  clock; single clock domain
- RST  in  1  reset; asynchronous, active-high
- TAG_FINISH  in  C_NUM_TAGS  bitmap of tags whose last packet was stored this cycle
- TAG_CLEAR  out  C_NUM_TAGS  one-hot pulse releasing a drained tag
- PKT_VALID  in  1  per-beat info valid
- PKT_TAG  in  C_TAG_WIDTH  tag of the PKT_* info
- PKT_WORDS  in  C_TAG_DW_COUNT_WIDTH  cumulative DWs stored for PKT_TAG
- PKT_ERR  in  1  packet error flag
- RAM_ADDR  out  C_DATA_ADDR_WIDTH*W  read address per bank; bank i in slice i
- RAM_DATA  in  C_PCI_DATA_WIDTH  bank read data; bank i in DW i; 1-cycle registered read
- ENG_VALID  out  1  output beat valid
- ENG_DATA  out  C_PCI_DATA_WIDTH  in-order payload, lowest DW first
- ENG_DATA_EN  out  C_PCI_DATA_COUNT_WIDTH  valid DWs in beat, packed from DW0
- ENG_DONE  out  1  last beat of current tag
- ENG_ERR  out  1  tag had an error; valid on the ENG_DONE beat
- ENG_TAG  out  C_TAG_WIDTH  tag being emitted

## Operation
- Per-tag registers:
  - rWords[t] and rErr[t] are written whenever PKT_VALID is high for tag t. rWords takes PKT_WORDS; rErr takes rErr|PKT_ERR, so the last beat leaves the final count.
  - rFinished[t] is set by TAG_FINISH[t] and cleared when tag t is drained.
  - If a set and a clear of the same tag occur in the same cycle, the set wins.
  - rErr[t] and rWords[t] are cleared when tag t is drained.
- Head pointer rHead (C_TAG_WIDTH): starts at 0, increments modulo C_NUM_TAGS after each drained tag. Tags are drained strictly in ascending, wrapping order.
- Data layout: DW n of tag t lives in bank n mod W at address (t<<C_DATA_ADDR_STRIDE_WIDTH) + n/W. Beat k therefore reads base+k on all banks, and no rotation is needed.
- FSM states IDLE and READ.
  - IDLE: if rFinished[rHead], load rRemain=rWords[rHead], rBeat=0, rLastErr=rErr[rHead], then go to READ. Otherwise stay in IDLE.
  - READ: drive RAM_ADDR=base+rBeat on all banks. Issue an internal read-valid with count cnt=min(W,rRemain), plus a last flag when rRemain<=W. Then rBeat++ and rRemain-=cnt.
  - READ, last beat: pulse TAG_CLEAR one-hot at rHead, clear rFinished/rWords/rErr[rHead], increment rHead, and return to IDLE.
- Zero-word tag (error-only completion): one READ beat with cnt=0, ENG_DONE=1 and ENG_ERR=rErr.
- The upstream stage guarantees ceil(words/W) <= 2**C_DATA_ADDR_STRIDE_WIDTH. Larger counts are undefined.
- There is no backpressure: the engine must accept every ENG_VALID beat.

## Timing
- The read pipeline has two stages:
  - Cycle c: READ drives RAM_ADDR.
  - Cycle c+1: RAM_DATA is valid.
  - Cycle c+2: ENG_VALID/DATA/DATA_EN/DONE/ERR/TAG are registered out together.
- TAG_FINISH[t] in cycle F, with t at the head and the FSM in IDLE:
  - rFinished is set at the F edge.
  - IDLE sees it in F+1.
  - First READ is in F+2.
  - First ENG_VALID is in F+4.
- A tag of B beats produces B consecutive ENG_VALID cycles. There is one IDLE bubble between tags, so the next tag's first beat follows at least 2 cycles after the previous ENG_DONE.
- TAG_CLEAR pulses in the cycle after the last READ cycle, 1 cycle wide, and precedes that tag's ENG_DONE by 1 cycle.
- Reset (async, any time, including mid-tag):
  - All outputs go to 0 immediately: ENG_*, TAG_CLEAR, RAM_ADDR.
  - FSM goes to IDLE, rHead=0, and all per-tag state is cleared.
  - In-flight pipeline beats are discarded.
- A non-head tag finishing early waits, with no output, until every older tag has drained.

## Test plan
- W=4, tag 0 with PKT_WORDS=10 then TAG_FINISH[0] -> 3 beats: ENG_DATA_EN 4,4,2. RAM_ADDR 0,1,2. ENG_DONE on beat 3. TAG_CLEAR=0x1 one cycle before ENG_DONE.
- Out of order: tag 1 (4 DW) finishes, then tag 0 (8 DW) finishes 10 cycles later -> no output until tag 0 finishes. Tag 0 emits 2 beats, then tag 1 emits 1 beat at RAM_ADDR 32. TAG_CLEAR 0x1 then 0x2.
- Tag 3, zero words, PKT_ERR=1 -> single beat: ENG_DATA_EN=0, ENG_DONE=1, ENG_ERR=1, ENG_TAG=3.
- Wrap: drain tags 0..31 with 1 DW each, then tag 0 again -> ENG_TAG runs 0..31 then 0. rHead wraps with no stall.
- Assert RST during beat 2 of a 5-beat tag -> all outputs 0 the same cycle. After release, re-finishing tag 0 replays from RAM_ADDR 0.
- TAG_FINISH[5] in the same cycle as TAG_CLEAR for tag 5 after a wrap -> tag 5 stays finished and is drained on the next pass.
